// File: rtl/hc595_rx.sv
// hc595_rx: serial-to-parallel receiver for a 74HC595-style three-wire link.
// ds/shcp/stcp/oe are synchronized into sys_clk; each shcp rise shifts one bit
// in LSB-first, each stcp rise latches the frame and pulses frame_vld.
// Optional build macro HC595_RX_FRAME_CHK_EN adds a bit counter and frame_err
// (pulses when a latch does not follow exactly DATA_W shifts).
module hc595_rx #(
    parameter int SEG_W = 8,
    parameter int SEL_W = 6
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             ds,
    input  logic             shcp,
    input  logic             stcp,
    input  logic             oe,
    output logic [SEG_W-1:0] seg,
    output logic [SEL_W-1:0] sel,
    output logic             frame_vld,
    output logic             frame_err
);

    localparam int DATA_W = SEG_W + SEL_W;

    // synchronizer stages; s3 is only kept where an edge or the oe delay needs it
    logic r_ds_s1, r_ds_s2;
    logic r_shcp_s1, r_shcp_s2, r_shcp_s3;
    logic r_stcp_s1, r_stcp_s2, r_stcp_s3;
    logic r_oe_s1, r_oe_s2, r_oe_s3;

    logic [DATA_W-1:0] r_sr;
    logic [DATA_W-1:0] r_st;
    logic              r_vld_p;

    logic w_shcp_rise;
    logic w_stcp_rise;

    assign w_shcp_rise = r_shcp_s2 & ~r_shcp_s3;
    assign w_stcp_rise = r_stcp_s2 & ~r_stcp_s3;

    // bring the asynchronous link lines into the sys_clk domain
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_ds_s1   <= 1'b0;
            r_ds_s2   <= 1'b0;
            r_shcp_s1 <= 1'b0;
            r_shcp_s2 <= 1'b0;
            r_shcp_s3 <= 1'b0;
            r_stcp_s1 <= 1'b0;
            r_stcp_s2 <= 1'b0;
            r_stcp_s3 <= 1'b0;
            r_oe_s1   <= 1'b0;
            r_oe_s2   <= 1'b0;
            r_oe_s3   <= 1'b0;
        end else begin
            r_ds_s1   <= ds;
            r_ds_s2   <= r_ds_s1;
            r_shcp_s1 <= shcp;
            r_shcp_s2 <= r_shcp_s1;
            r_shcp_s3 <= r_shcp_s2;
            r_stcp_s1 <= stcp;
            r_stcp_s2 <= r_stcp_s1;
            r_stcp_s3 <= r_stcp_s2;
            r_oe_s1   <= oe;
            r_oe_s2   <= r_oe_s1;
            r_oe_s3   <= r_oe_s2;
        end
    end

    // shift on shcp rise; latch on stcp rise (pre-shift value when both rise)
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_sr    <= {DATA_W{1'b0}};
            r_st    <= {DATA_W{1'b0}};
            r_vld_p <= 1'b0;
        end else begin
            if (w_shcp_rise) begin
                r_sr <= {r_ds_s2, r_sr[DATA_W-1:1]};
            end else begin
                r_sr <= r_sr;
            end
            if (w_stcp_rise) begin
                r_st <= r_sr;
            end else begin
                r_st <= r_st;
            end
            r_vld_p <= w_stcp_rise;
        end
    end

    // registered parallel outputs; oe uses one extra stage to match data latency
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            seg       <= {SEG_W{1'b0}};
            sel       <= {SEL_W{1'b0}};
            frame_vld <= 1'b0;
        end else begin
            if (r_oe_s3) begin
                seg <= {SEG_W{1'b0}};
                sel <= {SEL_W{1'b0}};
            end else begin
                seg <= r_st[DATA_W-1:SEL_W];
                sel <= r_st[SEL_W-1:0];
            end
            frame_vld <= r_vld_p;
        end
    end

`ifdef HC595_RX_FRAME_CHK_EN
    logic [4:0] r_bit_cnt;
    logic       r_err_p;
    logic       r_frame_err;

    // count shifts since the last latch; a shift coinciding with a latch
    // belongs to the next frame, so the count restarts at one
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_bit_cnt   <= 5'd0;
            r_err_p     <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_stcp_rise && w_shcp_rise) begin
                r_bit_cnt <= 5'd1;
            end else if (w_stcp_rise) begin
                r_bit_cnt <= 5'd0;
            end else if (w_shcp_rise && (r_bit_cnt != 5'd31)) begin
                r_bit_cnt <= r_bit_cnt + 5'd1;
            end else begin
                r_bit_cnt <= r_bit_cnt;
            end
            r_err_p     <= w_stcp_rise && (r_bit_cnt != 5'(DATA_W));
            r_frame_err <= r_err_p;
        end
    end

    assign frame_err = r_frame_err;
`else
    assign frame_err = 1'b0;
`endif

endmodule
